main_vid_bus: RTL and testbench

MAIN_VID_BUS -- requirements
Module: main_vid_bus

---
 rtl/main_vid_bus.sv | 239 +++++++++++++++++++++++
 tb/tb_main_vid_bus.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_vid_bus.sv
// main_vid_bus -- video bus: CPU-visible video memories plus video-side read ports.
//
// Purpose
//   Decodes the CPU memory window C000-E044 into colour RAM, video (tile code)
//   RAM, two 256-byte sprite banks, work RAM, 32 row-scroll registers and two
//   control registers. The CPU port runs on the falling edge of CPUCL. The video
//   ports (BG tiles, sprites, row scroll) are registered on VCLK.
//
// Build option
//   SPRITE_DBUF_EN : adds a 256-byte sprite shadow buffer. A VCLK-domain copy
//                    FSM (IDLE/COPY/DONE) refreshes it from the displayed bank
//                    when PV steps 239->240. SPAD then reads the shadow.
//                    Without it, SPAD reads the displayed bank directly.
//
// Ports
//   CPUCL, VCLK         CPU clock (falling-edge active) / pixel clock
//   RESET               synchronous, active-high, sampled in each clock domain
//   PV[8:0]             current video line (VCLK domain)
//   CPUMX, CPUWR        memory request / write strobe
//   CPUAD[15:0]         CPU address
//   CPUWD[7:0]          CPU write data
//   VIDDV, VIDRD[7:0]   read-data valid (combinational) / registered read data
//   BGVA[10:0]          tile address   -> BGVD[15:0] = {colour, code}, 1 VCLK
//   SPAA[7:0]           sprite address -> SPAD[7:0], 1 VCLK
//   SCRI[4:0]           row index      -> SCRX[7:0], 1 VCLK
//   FLIP, SPBK          screen flip / displayed sprite bank (CPUCL domain)
//   o_copy_state[1:0]   copy FSM state (0 idle, 1 copy, 2 done); 0 when the
//                       shadow buffer is not built
//
// Handshake: there is no backpressure. A CPU access is a single-cycle request
// qualified by CPUMX. CPUWR selects the direction. Read data is captured on the
// same falling edge and held until the next valid read.
module main_vid_bus (
  input  logic        CPUCL,
  input  logic        VCLK,
  input  logic        RESET,
  input  logic [8:0]  PV,
  input  logic        CPUMX,
  input  logic        CPUWR,
  input  logic [15:0] CPUAD,
  input  logic [7:0]  CPUWD,
  output logic        VIDDV,
  output logic [7:0]  VIDRD,
  input  logic [10:0] BGVA,
  output logic [15:0] BGVD,
  input  logic [7:0]  SPAA,
  output logic [7:0]  SPAD,
  input  logic [4:0]  SCRI,
  output logic [7:0]  SCRX,
  output logic        FLIP,
  output logic        SPBK,
  output logic [1:0]  o_copy_state
);

  // Memories (never reset)
  logic [7:0] r_col_ram [0:2047];
  logic [7:0] r_vid_ram [0:2047];
  logic [7:0] r_spr_ram [0:511];   // {bank, index}
  logic [7:0] r_wrk_ram [0:3583];  // D200-DFFF

  // CPUCL-domain registers
  logic [31:0][7:0] r_scroll;
  logic [7:0]       r_vidrd;
  logic             r_flip;
  logic             r_spbk;

  // VCLK-domain registers
  logic        r_spbk_s1;
  logic        r_spbk_s2;
  logic [15:0] r_bgvd;
  logic [7:0]  r_scrx;
  logic [7:0]  r_spad;

  // Address decode
  logic        w_col, w_vid, w_spr, w_wrk, w_scr, w_bank, w_ctl;
  logic        w_rd_hit, w_cpu_wr, w_cpu_rd;
  logic [11:0] w_wrk_idx;

  assign w_col  = (CPUAD[15:11] == 5'b11000);
  assign w_vid  = (CPUAD[15:11] == 5'b11001);
  assign w_spr  = (CPUAD[15:9]  == 7'b1101000);
  assign w_wrk  = (CPUAD[15:12] == 4'hD) && !w_spr;
  assign w_scr  = (CPUAD[15:5]  == 11'b11100000000);
  assign w_bank = (CPUAD == 16'hE043);
  assign w_ctl  = (CPUAD == 16'hE044);

  // Work RAM starts at D200, so rebase to 0.
  assign w_wrk_idx = CPUAD[11:0] - 12'h200;

  assign w_cpu_wr = CPUMX && CPUWR;
  assign w_cpu_rd = CPUMX && !CPUWR;

  // The control registers are write-only, so they do not report valid data.
  assign w_rd_hit = w_col || w_vid || w_spr || w_wrk || w_scr;
  assign VIDDV    = w_cpu_rd && w_rd_hit;

  // CPU write ports
  always_ff @(negedge CPUCL) begin
    if (w_cpu_wr && w_col) r_col_ram[CPUAD[10:0]] <= CPUWD;
  end

  always_ff @(negedge CPUCL) begin
    if (w_cpu_wr && w_vid) r_vid_ram[CPUAD[10:0]] <= CPUWD;
  end

  always_ff @(negedge CPUCL) begin
    if (w_cpu_wr && w_spr) r_spr_ram[CPUAD[8:0]] <= CPUWD;
  end

  always_ff @(negedge CPUCL) begin
    if (w_cpu_wr && w_wrk) r_wrk_ram[w_wrk_idx] <= CPUWD;
  end

  // CPU registers and read-data capture
  always_ff @(negedge CPUCL) begin
    if (RESET) begin
      r_vidrd  <= 8'h00;
      r_flip   <= 1'b0;
      r_spbk   <= 1'b0;
      r_scroll <= '0;
    end else if (w_cpu_wr) begin
      if (w_scr)  r_scroll[CPUAD[4:0]] <= CPUWD;
      if (w_bank) r_spbk <= CPUWD[0];
      if (w_ctl)  r_flip <= CPUWD[3];
    end else if (w_cpu_rd) begin
      if (w_col)      r_vidrd <= r_col_ram[CPUAD[10:0]];
      else if (w_vid) r_vidrd <= r_vid_ram[CPUAD[10:0]];
      else if (w_spr) r_vidrd <= r_spr_ram[CPUAD[8:0]];
      else if (w_wrk) r_vidrd <= r_wrk_ram[w_wrk_idx];
      else if (w_scr) r_vidrd <= r_scroll[CPUAD[4:0]];
    end
  end

  assign VIDRD = r_vidrd;
  assign FLIP  = r_flip;
  assign SPBK  = r_spbk;

  // Video-side ports. SPBK crosses into VCLK through two flops. Scroll values
  // are quasi-static, so they are sampled directly.
  always_ff @(posedge VCLK) begin
    if (RESET) begin
      r_spbk_s1 <= 1'b0;
      r_spbk_s2 <= 1'b0;
      r_bgvd    <= 16'h0000;
      r_scrx    <= 8'h00;
    end else begin
      r_spbk_s1 <= r_spbk;
      r_spbk_s2 <= r_spbk_s1;
      r_bgvd    <= {r_col_ram[BGVA], r_vid_ram[BGVA]};
      r_scrx    <= r_scroll[SCRI];
    end
  end

  assign BGVD = r_bgvd;
  assign SCRX = r_scrx;

`ifdef SPRITE_DBUF_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_COPY = 2'd1,
    ST_DONE = 2'd2
  } copy_state_t;

  copy_state_t r_state;
  logic [8:0]  r_cnt;       // next read index; bit 8 set once all 256 are read
  logic        r_src_bank;  // bank frozen at COPY entry
  logic        r_wr_pend;
  logic [7:0]  r_wr_idx;
  logic [7:0]  r_wr_data;
  logic [8:0]  r_pv_prev;
  logic [7:0]  r_shadow [0:255];

  // Copy pipeline: read bank byte N on one VCLK, write it to the shadow on
  // the next. The final write of index 255 lands 257 VCLKs after entry.
  always_ff @(posedge VCLK) begin
    if (RESET) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 9'd0;
      r_src_bank <= 1'b0;
      r_wr_pend  <= 1'b0;
      r_wr_idx   <= 8'h00;
      r_wr_data  <= 8'h00;
      r_pv_prev  <= 9'd0;
      r_spad     <= 8'h00;
    end else begin
      r_pv_prev <= PV;
      r_spad    <= r_shadow[SPAA];
      case (r_state)
        ST_IDLE: begin
          if (r_pv_prev == 9'd239 && PV == 9'd240) begin
            r_state    <= ST_COPY;
            r_cnt      <= 9'd0;
            r_src_bank <= r_spbk_s2;
            r_wr_pend  <= 1'b0;
          end
        end
        ST_COPY: begin
          if (!r_cnt[8]) begin
            r_wr_data <= r_spr_ram[{r_src_bank, r_cnt[7:0]}];
            r_wr_idx  <= r_cnt[7:0];
            r_wr_pend <= 1'b1;
            r_cnt     <= r_cnt + 9'd1;
          end else begin
            r_wr_pend <= 1'b0;
          end
          if (r_wr_pend && r_wr_idx == 8'hFF) begin
            r_state   <= ST_DONE;
            r_wr_pend <= 1'b0;
          end
        end
        ST_DONE: begin
          if (PV == 9'd0) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Gated by RESET so a copy aborted mid-way drops its pending byte.
  always_ff @(posedge VCLK) begin
    if (!RESET && r_wr_pend) r_shadow[r_wr_idx] <= r_wr_data;
  end

  assign o_copy_state = r_state;
`else
  logic w_unused_pv;
  assign w_unused_pv = ^PV;

  always_ff @(posedge VCLK) begin
    if (RESET) r_spad <= 8'h00;
    else       r_spad <= r_spr_ram[{r_spbk_s2, SPAA}];
  end

  assign o_copy_state = 2'b00;
`endif

  assign SPAD = r_spad;

endmodule

// File: tb/tb_main_vid_bus.sv
// tb_main_vid_bus -- directed bench for main_vid_bus with an expected-value queue.
// Build with SPRITE_DBUF_EN defined to exercise the sprite shadow buffer path.
module tb_main_vid_bus;

  logic        CPUCL, VCLK, RESET;
  logic [8:0]  PV;
  logic        CPUMX, CPUWR;
  logic [15:0] CPUAD;
  logic [7:0]  CPUWD;
  logic        VIDDV;
  logic [7:0]  VIDRD;
  logic [10:0] BGVA;
  logic [15:0] BGVD;
  logic [7:0]  SPAA;
  logic [7:0]  SPAD;
  logic [4:0]  SCRI;
  logic [7:0]  SCRX;
  logic        FLIP, SPBK;
  logic [1:0]  o_copy_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  main_vid_bus dut (
    .CPUCL(CPUCL), .VCLK(VCLK), .RESET(RESET), .PV(PV),
    .CPUMX(CPUMX), .CPUWR(CPUWR), .CPUAD(CPUAD), .CPUWD(CPUWD),
    .VIDDV(VIDDV), .VIDRD(VIDRD), .BGVA(BGVA), .BGVD(BGVD),
    .SPAA(SPAA), .SPAD(SPAD), .SCRI(SCRI), .SCRX(SCRX),
    .FLIP(FLIP), .SPBK(SPBK), .o_copy_state(o_copy_state)
  );

  // Clock / reset
  initial begin
    CPUCL = 1'b0;
    VCLK  = 1'b0;
  end
  always #10 CPUCL = ~CPUCL;
  always #7  VCLK  = ~VCLK;

  // Scoreboard
  task automatic push_exp(input string tag, input logic [15:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_out(input logic [15:0] obs);
    logic [15:0] e;
    string       t;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  // Drivers
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge CPUCL); #1;
    CPUMX = 1'b1; CPUWR = 1'b1; CPUAD = a; CPUWD = d;
    @(posedge CPUCL); #1;
    CPUMX = 1'b0; CPUWR = 1'b0;
  endtask

  task automatic cpu_read(input string tag, input logic [15:0] a,
                          input logic exp_dv, input logic [7:0] exp_rd);
    @(posedge CPUCL); #1;
    CPUMX = 1'b1; CPUWR = 1'b0; CPUAD = a;
    push_exp({tag, "_dv"}, {15'd0, exp_dv});
    #1 check_out({15'd0, VIDDV});
    if (exp_dv) push_exp({tag, "_rd"}, {8'd0, exp_rd});
    @(posedge CPUCL); #1;
    if (exp_dv) check_out({8'd0, VIDRD});
    CPUMX = 1'b0;
  endtask

  task automatic vclk_wait(input int n);
    repeat (n) @(posedge VCLK);
    #1;
  endtask

  task automatic bg_check(input string tag, input logic [10:0] a, input logic [15:0] e);
    @(posedge VCLK); #1;
    BGVA = a;
    push_exp(tag, e);
    @(posedge VCLK); #1;
    check_out(BGVD);
  endtask

  task automatic spad_check(input string tag, input logic [7:0] a, input logic [7:0] e);
    @(posedge VCLK); #1;
    SPAA = a;
    push_exp(tag, {8'd0, e});
    vclk_wait(2);
    check_out({8'd0, SPAD});
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (4) @(posedge CPUCL);
    #1;
  endtask

  logic [7:0]  rnd_a, rnd_b;
  logic [10:0] bg_a;
  int          k;

  initial begin
    RESET = 1'b1; PV = 9'd0; CPUMX = 1'b0; CPUWR = 1'b0; CPUAD = 16'h0;
    CPUWD = 8'h0; BGVA = 11'h0; SPAA = 8'h0; SCRI = 5'd0;

    // Reset state, sampled while RESET is held
    do_reset();
    push_exp("rst_vidrd", 16'h0);  check_out({8'd0, VIDRD});
    push_exp("rst_flip", 16'h0);   check_out({15'd0, FLIP});
    push_exp("rst_spbk", 16'h0);   check_out({15'd0, SPBK});
    push_exp("rst_scrx", 16'h0);   check_out({8'd0, SCRX});
    push_exp("rst_bgvd", 16'h0);   check_out(BGVD);
    push_exp("rst_spad", 16'h0);   check_out({8'd0, SPAD});
    push_exp("rst_state", 16'h0);  check_out({14'd0, o_copy_state});
    RESET = 1'b0;

    // Colour/video RAM and BG port
    cpu_write(16'hC812, 8'h5A);
    cpu_write(16'hC012, 8'hA5);
    cpu_read("rd_c812", 16'hC812, 1'b1, 8'h5A);
    cpu_read("rd_c012", 16'hC012, 1'b1, 8'hA5);
    bg_check("bgvd_012", 11'h012, 16'hA55A);

    // Row scroll, decode edges, write-only registers
    cpu_write(16'hE007, 8'h3C);
    @(posedge VCLK); #1 SCRI = 5'd7;
    push_exp("scrx_7", 16'h003C);
    vclk_wait(3);
    check_out({8'd0, SCRX});
    cpu_read("rd_e007", 16'hE007, 1'b1, 8'h3C);
    cpu_read("rd_e044", 16'hE044, 1'b0, 8'h00);
    cpu_read("rd_e043", 16'hE043, 1'b0, 8'h00);
    cpu_write(16'hE000, 8'h11);
    cpu_write(16'hE020, 8'h22);
    cpu_read("rd_e000", 16'hE000, 1'b1, 8'h11);
    cpu_read("rd_e020", 16'hE020, 1'b0, 8'h00);

    // Work RAM ends and sprite RAM through the CPU port
    rnd_a = 8'($urandom_range(0, 255));
    rnd_b = 8'($urandom_range(0, 255));
    cpu_write(16'hD200, rnd_a);
    cpu_write(16'hDFFF, rnd_b);
    cpu_write(16'hD0FF, 8'hC3);
    cpu_read("rd_d200", 16'hD200, 1'b1, rnd_a);
    cpu_read("rd_dfff", 16'hDFFF, 1'b1, rnd_b);
    cpu_read("rd_d0ff", 16'hD0FF, 1'b1, 8'hC3);

    // Randomised BG fetches, one per 256-byte block
    for (int i = 0; i < 4; i++) begin
      bg_a  = 11'(i * 256 + 128 + $urandom_range(0, 127));
      rnd_a = 8'($urandom_range(0, 255));
      rnd_b = 8'($urandom_range(0, 255));
      cpu_write(16'hC000 | 16'(bg_a), rnd_a);
      cpu_write(16'hC800 | 16'(bg_a), rnd_b);
      bg_check("bgvd_rand", bg_a, {rnd_a, rnd_b});
    end

    // FLIP / SPBK control bits and reset of CPU-side state
    cpu_write(16'hE044, 8'h08);
    push_exp("flip_set", 16'h1);   check_out({15'd0, FLIP});
    cpu_write(16'hE044, 8'hF7);
    push_exp("flip_bit3", 16'h0);  check_out({15'd0, FLIP});
    cpu_write(16'hE043, 8'h01);
    push_exp("spbk_set", 16'h1);   check_out({15'd0, SPBK});
    do_reset();
    push_exp("rst2_flip", 16'h0);  check_out({15'd0, FLIP});
    push_exp("rst2_spbk", 16'h0);  check_out({15'd0, SPBK});
    push_exp("rst2_scrx", 16'h0);  check_out({8'd0, SCRX});
    RESET = 1'b0;
    cpu_read("rd_e007_rst", 16'hE007, 1'b1, 8'h00);
    cpu_read("rd_c812_keep", 16'hC812, 1'b1, 8'h5A);

`ifdef SPRITE_DBUF_EN
    // Fill bank 1 with index^FF, display bank 1, run a copy
    for (int i = 0; i < 256; i++) cpu_write(16'hD100 + 16'(i), 8'(i) ^ 8'hFF);
    cpu_write(16'hE043, 8'h01);
    @(posedge VCLK); #1 PV = 9'd239;
    vclk_wait(4);
    push_exp("st_idle", 16'h0);    check_out({14'd0, o_copy_state});
    @(posedge VCLK); #1 PV = 9'd240;
    repeat (257) @(posedge VCLK);
    #1;
    push_exp("st_copy_257", 16'h1); check_out({14'd0, o_copy_state});
    @(posedge VCLK); #1;
    push_exp("st_done", 16'h2);    check_out({14'd0, o_copy_state});
    spad_check("spad_10", 8'h10, 8'hEF);
    spad_check("spad_ff", 8'hFF, 8'h00);
    spad_check("spad_00", 8'h00, 8'hFF);

    // Mid-frame bank write must not reach the shadow until the next copy
    cpu_write(16'hD110, 8'h00);
    spad_check("spad_10_hold", 8'h10, 8'hEF);
    @(posedge VCLK); #1 PV = 9'd0;
    vclk_wait(2);
    push_exp("st_back_idle", 16'h0); check_out({14'd0, o_copy_state});
    PV = 9'd239;
    vclk_wait(3);
    @(posedge VCLK); #1 PV = 9'd240;
    vclk_wait(262);
    spad_check("spad_10_next", 8'h10, 8'h00);

    // Abort a copy from bank 0 at index 100
    for (int i = 0; i < 256; i++) cpu_write(16'hD000 + 16'(i), 8'(i));
    cpu_write(16'hE043, 8'h00);
    @(posedge VCLK); #1 PV = 9'd0;
    vclk_wait(2);
    PV = 9'd239;
    vclk_wait(4);
    @(posedge VCLK); #1 PV = 9'd240;
    repeat (102) @(posedge VCLK);
    #1;
    push_exp("st_midcopy", 16'h1); check_out({14'd0, o_copy_state});
    RESET = 1'b1;
    PV = 9'd0;
    repeat (4) @(posedge CPUCL);
    #1;
    push_exp("st_abort", 16'h0);   check_out({14'd0, o_copy_state});
    RESET = 1'b0;
    spad_check("abort_99", 8'd99, 8'd99);
    spad_check("abort_100", 8'd100, 8'd100 ^ 8'hFF);
    spad_check("abort_255", 8'd255, 8'h00);
    for (int i = 0; i < 3; i++) begin
      k = $urandom_range(17, 98);
      spad_check("abort_lo", 8'(k), 8'(k));
      k = $urandom_range(101, 254);
      spad_check("abort_hi", 8'(k), 8'(k) ^ 8'hFF);
    end
    vclk_wait(300);
    push_exp("st_stay_idle", 16'h0); check_out({14'd0, o_copy_state});
`else
    // Direct sprite path through the synchronised bank select
    cpu_write(16'hD020, 8'h77);
    cpu_write(16'hD120, 8'h99);
    @(posedge VCLK); #1 SPAA = 8'h20;
    push_exp("spad_b0", 16'h0077);
    vclk_wait(4);
    check_out({8'd0, SPAD});
    cpu_write(16'hE043, 8'h01);
    push_exp("spad_b1", 16'h0099);
    vclk_wait(5);
    check_out({8'd0, SPAD});
    cpu_write(16'hE043, 8'h00);
    push_exp("spad_b0_again", 16'h0077);
    vclk_wait(5);
    check_out({8'd0, SPAD});
    push_exp("st_none", 16'h0);    check_out({14'd0, o_copy_state});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
